cpu_ctrl_fsm: RTL
=================

Name: cpu_ctrl_fsm

Overview:
- Multicycle control unit for the CPU datapath.
- Sequences each ARM instruction (data-processing reg/imm, LDR/STR with immediate offset, B/BL) through fetch, decode, execute, memory and writeback states.
- Drives every datapath mux select and write enable, and evaluates the condition field against the internal NZCV flags.
- Sits between instruction register/flags and the shared register-file/ALU/memory datapath.

Parameters:
- INSTR_W, 32, instruction width.
- FLAG_W, 4, ALU flag width (N,Z,C,V).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- inst  in  32  current instruction-register contents.
- alu_flags  in  4  NZCV from ALU this cycle.
- pc_write  out  1  PC load enable.
- adr_src  out  1  memory address select: 0=PC, 1=ALU result register.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register load.
- reg_write  out  1  register file write enable.
- result_src  out  2  00=ALU out reg, 01=mem data, 10=ALU result direct.
- alu_src_a  out  1  0=reg A, 1=PC.
- alu_src_b  out  2  00=reg B, 01=ext imm, 10=constant 4.
- imm_src  out  2  00=imm8 rot, 01=imm12, 10=imm24 branch.
- alu_control  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MOV.
- illegal  out  1  one-cycle pulse on unsupported encoding.

Behaviour:
- Field decode: cond=inst[31:28], op=inst[27:26], funct=inst[25:20], rd=inst[15:12].
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH. Encoding is held in the shared package.
- Async reset (rst=0):
  - state=FETCH, flags=0.
  - All outputs 0 while rst low, including ir_write and pc_write.
  - Reset mid-instruction abandons it; fetch restarts on the first clk edge after release.
- FETCH:
  - Asserts ir_write, pc_write, adr_src=0, alu_src_a=1, alu_src_b=10, alu_control=ADD, result_src=10.
  - Always goes to DECODE.
- DECODE: alu_src_a=1, alu_src_b=10, ADD (PC+8). Next state by op:
  - op=00, funct[5]=0: EXECR.
  - op=00, funct[5]=1: EXECI.
  - op=01: MEMADR.
  - op=10: BRANCH.
  - op=11: illegal=1, then FETCH.
- EXECR / EXECI:
  - ALU op from cmd=funct[4:1]: 0100 ADD, 0010 SUB, 1010 CMP(SUB), 0000 AND, 1100 ORR, 1101 MOV.
  - Any other cmd: illegal=1, next FETCH, no writes.
  - Next state ALUWB, except CMP, which goes to FETCH.
- ALUWB: reg_write=cond_ex, result_src=00. If rd==15, pc_write=cond_ex as well.
- MEMADR:
  - alu_src_b=01, imm_src=01.
  - ADD if U=funct[3]=1, else SUB.
  - funct[0]=1 goes to MEMRD, 0 goes to MEMWR.
- MEMRD: adr_src=1, then MEMWB.
- MEMWB: result_src=01, reg_write=cond_ex (plus PC rule as in ALUWB), then FETCH.
- MEMWR: adr_src=1, mem_write=cond_ex, then FETCH.
- BRANCH: alu_src_b=01, imm_src=10, ADD, result_src=10, pc_write=cond_ex, then FETCH.
- Latency (cycles):
  - Data-processing: 4; CMP: 3.
  - LDR: 5; STR: 4.
  - B: 3; illegal: 2.
- Condition logic:
  - cond_ex evaluated combinationally from cond and the registered flags.
  - All 15 ARM codes supported; 1111 is treated as never.
- Flag update:
  - Flags update in EXECR/EXECI when S=funct[0]=1 and cond_ex=1.
  - NZ always update; CV update only for ADD/SUB/CMP.
  - CMP always updates all four flags when cond_ex=1.
  - New flags are visible to the next instruction only, never to the same-cycle cond_ex.

Optional Feature:
- Macro: CPU_CTRL_MEM_WAIT_EN.
- Enabled:
  - Adds input mem_ready (1 bit).
  - FETCH, MEMRD and MEMWR hold their state and outputs until mem_ready=1.
  - ir_write/pc_write/mem_write remain asserted but are qualified by mem_ready.
- Disabled: no port; memory is single-cycle.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state_t enum.
  - alu_ctrl_t, result_src_t and alu_src_b_t encodings.
  - Cond-code constants (EQ..AL).
  - Cmd constants (ADD, SUB, AND, ORR, MOV, CMP).
- Sub-module cond_unit: flag register plus cond_ex evaluation and flag-write gating.
- cpu_ctrl_fsm itself holds the state register, next-state logic and output decode.

Test Plan:
- Reset: hold rst=0 for 3 cycles → all outputs 0. On release, first cycle FETCH: ir_write=1, pc_write=1.
- E3A02007 (MOV R2,#7) → FETCH, DECODE, EXECI (alu_control=100, alu_src_b=01), ALUWB (reg_write=1), FETCH. 4 cycles.
- E0825003 (ADD R5,R2,R3), then E2488004 (SUB R8,R8,#4) → alu_control 000 then 001; reg_write each in ALUWB; illegal stays 0.
- E5813A01 (STR) → MEMADR with alu_src_b=01, imm_src=01, ADD; MEMWR with adr_src=1, mem_write=1; reg_write never 1.
- E591AA01 (LDR R10) → MEMRD then MEMWB (result_src=01, reg_write=1). 5 cycles total.
- Condition check: CMP R0,R0 (E1500000) sets Z=1. Then 0A000002 (BEQ) → BRANCH pc_write=1. Then 1A000002 (BNE) → pc_write=0. An op=11 instruction → illegal pulse, then FETCH.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, datapath
// mux encodings, condition codes, data-processing commands and the
// condition-evaluation helper.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_MOV = 3'b100
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_MEM    = 2'b01,
        RES_ALU    = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

    localparam logic [1:0] IMM_ROT8 = 2'b00;
    localparam logic [1:0] IMM_12   = 2'b01;
    localparam logic [1:0] IMM_24   = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // Evaluate an ARM condition field against NZCV; 1111 never passes.
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return c;
            COND_CC: return !c;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return c && !z;
            COND_LS: return !c || z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z && (n == v);
            COND_LE: return z || (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_cond_unit.sv
// Condition unit: NZCV flag register, condition evaluation and flag-write
// gating. The pass/fail result seen in EXEC is held for the writeback state so
// that flags written by an instruction never alter its own writeback.
module cond_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cond,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              flag_wr_nz,
    input  logic              flag_wr_cv,
    input  logic              cond_latch,
    input  logic              use_latched,
    output logic              cond_ex
);

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              cond_hold_q, cond_hold_d;
    logic              cond_live;

    assign cond_live = cond_check(cond, flags_q);
    assign cond_ex   = use_latched ? cond_hold_q : cond_live;

    // Next flags (NZ and CV written independently) and held condition result.
    always_comb begin
        flags_d     = flags_q;
        cond_hold_d = cond_hold_q;
        if (cond_live && flag_wr_nz) flags_d[3:2] = alu_flags[3:2];
        if (cond_live && flag_wr_cv) flags_d[1:0] = alu_flags[1:0];
        if (cond_latch)              cond_hold_d  = cond_live;
    end

    // Flag and condition-hold registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q     <= '0;
            cond_hold_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            cond_hold_q <= cond_hold_d;
        end
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle ARM control unit: sequences DP reg/imm, LDR/STR and B/BL through
// fetch/decode/execute/memory/writeback and drives all datapath controls.
// Optional macro CPU_CTRL_MEM_WAIT_EN adds mem_ready; FETCH, MEMRD and MEMWR
// then stall until memory responds.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int FLAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef CPU_CTRL_MEM_WAIT_EN
    input  logic               mem_ready,
`endif
    input  logic [INSTR_W-1:0] inst,
    input  logic [FLAG_W-1:0]  alu_flags,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         imm_src,
    output logic [2:0]         alu_control,
    output logic               illegal
);

    state_t      state_q, state_d;
    logic [3:0]  cond, rd, cmd;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        rd_pc, cond_ex, mem_rdy;
    logic        flag_wr_nz, flag_wr_cv, cond_latch, use_latched;
    logic        legal, is_cmp, arith;

    logic        pc_w, adr_s, mem_w, ir_w, reg_w, src_a, ill;
    result_src_t res_s;
    alu_src_b_t  src_b;
    logic [1:0]  imm_s;
    alu_ctrl_t   alu_c;

    logic        unused_inst;

    assign cond  = inst[31:28];
    assign op    = inst[27:26];
    assign funct = inst[25:20];
    assign rd    = inst[15:12];
    assign cmd   = funct[4:1];
    assign rd_pc = (rd == 4'd15);
    assign unused_inst = ^{inst[19:16], inst[11:0]};

`ifdef CPU_CTRL_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    // Condition result is captured in EXEC and reused in ALUWB.
    assign cond_latch  = (state_q == S_EXECR) || (state_q == S_EXECI);
    assign use_latched = (state_q == S_ALUWB);

    cond_unit #(.FLAG_W(FLAG_W)) u_cond (
        .clk         (clk),
        .rst         (rst),
        .cond        (cond),
        .alu_flags   (alu_flags),
        .flag_wr_nz  (flag_wr_nz),
        .flag_wr_cv  (flag_wr_cv),
        .cond_latch  (cond_latch),
        .use_latched (use_latched),
        .cond_ex     (cond_ex)
    );

    // Data-processing command decode: legality, compare and arithmetic class.
    always_comb begin
        legal  = 1'b1;
        is_cmp = 1'b0;
        arith  = 1'b0;
        case (cmd)
            CMD_ADD: arith = 1'b1;
            CMD_SUB: arith = 1'b1;
            CMD_CMP: begin arith = 1'b1; is_cmp = 1'b1; end
            CMD_AND, CMD_ORR, CMD_MOV: ;
            default: legal = 1'b0;
        endcase
    end

    // Next-state and raw control decode for the current state.
    always_comb begin
        state_d    = state_q;
        pc_w       = 1'b0;
        adr_s      = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        res_s      = RES_ALUOUT;
        src_a      = 1'b0;
        src_b      = SRCB_REG;
        imm_s      = IMM_ROT8;
        alu_c      = ALU_ADD;
        ill        = 1'b0;
        flag_wr_nz = 1'b0;
        flag_wr_cv = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_w  = mem_rdy;
                pc_w  = mem_rdy;
                src_a = 1'b1;
                src_b = SRCB_FOUR;
                res_s = RES_ALU;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                src_a = 1'b1;
                src_b = SRCB_FOUR;
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: begin ill = 1'b1; state_d = S_FETCH; end
                endcase
            end
            S_EXECR, S_EXECI: begin
                src_b = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
                case (cmd)
                    CMD_ADD: alu_c = ALU_ADD;
                    CMD_SUB: alu_c = ALU_SUB;
                    CMD_CMP: alu_c = ALU_SUB;
                    CMD_AND: alu_c = ALU_AND;
                    CMD_ORR: alu_c = ALU_ORR;
                    CMD_MOV: alu_c = ALU_MOV;
                    default: alu_c = ALU_ADD;
                endcase
                if (!legal) begin
                    ill     = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    flag_wr_nz = funct[0] || is_cmp;
                    flag_wr_cv = (funct[0] || is_cmp) && arith;
                    state_d    = is_cmp ? S_FETCH : S_ALUWB;
                end
            end
            S_ALUWB: begin
                reg_w   = cond_ex;
                pc_w    = cond_ex && rd_pc;
                state_d = S_FETCH;
            end
            S_MEMADR: begin
                src_b   = SRCB_IMM;
                imm_s   = IMM_12;
                alu_c   = funct[3] ? ALU_ADD : ALU_SUB;
                state_d = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_s = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                res_s   = RES_MEM;
                reg_w   = cond_ex;
                pc_w    = cond_ex && rd_pc;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                adr_s = 1'b1;
                mem_w = cond_ex && mem_rdy;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_BRANCH: begin
                src_b   = SRCB_IMM;
                imm_s   = IMM_24;
                res_s   = RES_ALU;
                pc_w    = cond_ex;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    // Every control is forced low while reset is held.
    assign pc_write    = rst && pc_w;
    assign adr_src     = rst && adr_s;
    assign mem_write   = rst && mem_w;
    assign ir_write    = rst && ir_w;
    assign reg_write   = rst && reg_w;
    assign alu_src_a   = rst && src_a;
    assign illegal     = rst && ill;
    assign result_src  = rst ? res_s : 2'b00;
    assign alu_src_b   = rst ? src_b : 2'b00;
    assign imm_src     = rst ? imm_s : 2'b00;
    assign alu_control = rst ? alu_c : 3'b000;

endmodule
